pwm_compare_gen: RTL and testbench
==================================

Name: pwm_compare_gen

Overview:
- Consumer side of the 16-bit main counter in the PWM timer.
- Watches the free-running `cnt` value and drives the PWM waveform.
- Generates the period-terminal counter-clear request and the period interrupt.
- Double-buffers period/duty writes from the register interface so changes take effect only at a period boundary.

Parameters:
- CW, 16, width of `cnt`, period and duty values

Ports:
- slow_clk   in   1    divided timer clock; clocks all state
- rst        in   1    asynchronous, active-high system reset
- soft_rst   in   1    synchronous soft reset (ctrl[7]); same effect as rst, taken at next slow_clk edge
- enable     in   1    timer enable (ctrl[2])
- one_shot   in   1    1 = stop after one period; 0 = continuous
- cnt        in   CW   main counter value
- period_wr  in   CW   new period value
- duty_wr    in   CW   new duty value
- load       in   1    one-cycle strobe; captures period_wr/duty_wr into shadow registers
- irq_en     in   1    interrupt enable
- irq_clr    in   1    one-cycle strobe; clears irq_flag
- pwm_out    out  1    registered PWM output
- cnt_clr    out  1    combinational; instructs main counter to load 0 at next edge
- irq_flag   out  1    sticky period-terminal flag
- irq        out  1    irq_flag & irq_en
- busy       out  1    1 while state == RUN

Behaviour:
- Reset (rst async, or soft_rst sync) sets the following to 0:
  - pwm_out, irq_flag
  - shadow period/duty, active period/duty
  - pending
- Reset sets state = IDLE. After reset, cnt_clr = 0, irq = 0, busy = 0.
- Shadow load: `load` writes shadow_period/shadow_duty and sets pending.
- Shadow-to-active transfer (active <= shadow, pending <= 0):
  - in IDLE, every cycle pending = 1;
  - in RUN, only in a terminal cycle.
- load coincident with a transfer:
  - the old shadow values transfer;
  - the new values land in shadow;
  - pending stays 1 (load wins).
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when enable = 1 and active_period != 0.
  - RUN -> IDLE when enable = 0. Active regs are retained; pwm_out = 0 from the next cycle.
  - RUN -> DONE on a terminal cycle with one_shot = 1.
  - DONE -> IDLE when enable = 0. DONE holds pwm_out = 0 and asserts no cnt_clr.
- Terminal cycle: state == RUN, enable = 1, and cnt >= active_period - 1.
  - The >= comparison recovers from an overrun cnt left over from a previous larger period.
- cnt_clr: asserted combinationally during every terminal cycle. Counter period is therefore active_period slow_clk cycles (cnt 0 .. P-1).
- Period edge cases:
  - active_period = 0: block stays in IDLE; no cnt_clr, no irq.
  - active_period = 1: terminal every cycle.
- pwm_out, registered with one cycle of latency:
  - next pwm_out = (state == RUN) & enable & (cnt < active_duty);
  - on a terminal cycle it uses the duty value in force before the transfer.
- Duty edge cases:
  - duty = 0 -> constant 0.
  - duty >= period -> constant 1 while RUN.
- irq_flag:
  - set on every terminal cycle; held until irq_clr;
  - if set and irq_clr coincide, set wins;
  - irq_clr with flag already 0 has no effect.
- Comparisons are unsigned CW-bit. `active_period - 1` is computed only when active_period != 0, so no wrap.
- soft_rst and rst mid-period: outputs return to reset values immediately (rst) or at the next edge (soft_rst). Any pending shadow write is lost.

Test Plan:
- Continuous mode: period = 10, duty = 3, load, enable = 1, cnt driven by a model counter honouring cnt_clr.
  - Required: pwm_out high 3 / low 7 cycles repeating.
  - Required: cnt_clr pulses at cnt = 9 every 10 cycles; irq_flag sets at the first terminal cycle.
- Shadow update: while running with period = 10, load period = 4, duty = 2 at cnt = 5.
  - Required: current period completes at 10 cycles; the next period is 4 cycles with 2 high.
  - Corner: load exactly at cnt = 9 -> the old shadow transfers and the new value applies one period later.
- One-shot mode: one_shot = 1, period = 5, duty = 5.
  - Required: pwm_out high 5 cycles, single cnt_clr, state DONE, pwm_out stays 0.
  - Required: enable = 0 -> IDLE, busy = 0.
- Boundary values:
  - period = 0 with enable = 1 -> stays IDLE, no cnt_clr.
  - period = 1 -> cnt_clr every cycle, irq_flag set.
  - duty = 0 -> pwm_out always 0.
  - duty = 0xFFFF, period = 8 -> pwm_out always 1.
- Interrupt: irq_en = 0 at terminal -> irq_flag = 1, irq = 0; then set irq_en = 1 -> irq = 1.
  - irq_clr on a terminal cycle -> flag remains 1.
  - irq_clr alone -> flag = 0.
- Resets:
  - assert rst mid-period at cnt = 6 -> all outputs 0 immediately, active/shadow cleared.
  - repeat with soft_rst -> same result one edge later.
  - overrun entry: cnt = 20 with period = 8 -> cnt_clr asserted in the first RUN cycle.

Source files
------------

// File: rtl/pwm_compare_gen_if.sv
// Register-side bus of the PWM compare generator: double-buffered period/duty
// writes, interrupt enable/clear, and the interrupt status going back.
interface pwm_compare_gen_if #(
  parameter int CW = 16
);
  logic [CW-1:0] period_wr;
  logic [CW-1:0] duty_wr;
  logic          load;
  logic          irq_en;
  logic          irq_clr;
  logic          irq_flag;
  logic          irq;

  modport master (
    output period_wr, duty_wr, load, irq_en, irq_clr,
    input  irq_flag, irq
  );

  modport slave (
    input  period_wr, duty_wr, load, irq_en, irq_clr,
    output irq_flag, irq
  );
endinterface

// File: rtl/pwm_compare_gen.sv
// PWM compare stage: watches the main counter, drives pwm_out, requests the
// period-terminal counter clear and raises the period interrupt.
//
// state | meaning
// IDLE  | stopped; pending shadow values move to active every cycle
// RUN   | generating PWM; shadow moves to active only on a terminal cycle
// DONE  | one-shot period finished; output held low until enable drops
module pwm_compare_gen #(
  parameter int CW = 16
) (
  input  logic          slow_clk,
  input  logic          rst,
  input  logic          soft_rst,
  input  logic          enable,
  input  logic          one_shot,
  input  logic [CW-1:0] cnt,
  pwm_compare_gen_if.slave regs,
  output logic          pwm_out,
  output logic          cnt_clr,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] shadow_period, shadow_duty;
  logic [CW-1:0] active_period, active_duty;
  logic          pending;
  logic          terminal;
  logic          xfer;
  logic          pwm_nxt;

  // >= rather than == so an overrun count left from a longer period still ends it
  assign terminal = (state == RUN) && enable && (active_period != '0) &&
                    (cnt >= active_period - CW'(1));
  assign xfer     = pending && ((state == IDLE) || terminal);
  assign pwm_nxt  = (state == RUN) && enable && (cnt < active_duty);

  assign cnt_clr  = terminal;
  assign busy     = (state == RUN);
  assign regs.irq = regs.irq_flag & regs.irq_en;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst)           state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && (active_period != '0)) state_nxt = RUN;
      RUN: begin
        if (!enable)                    state_nxt = IDLE;
        else if (terminal && one_shot)  state_nxt = DONE;
      end
      DONE: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      active_period <= '0;
      active_duty   <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      regs.irq_flag <= 1'b0;
    end else if (soft_rst) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      active_period <= '0;
      active_duty   <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      regs.irq_flag <= 1'b0;
    end else begin
      pwm_out <= pwm_nxt;
      if (xfer) begin
        active_period <= shadow_period;
        active_duty   <= shadow_duty;
      end
      // a load in the same cycle as a transfer keeps pending set for its new values
      if (regs.load) begin
        shadow_period <= regs.period_wr;
        shadow_duty   <= regs.duty_wr;
        pending       <= 1'b1;
      end else if (xfer) begin
        pending       <= 1'b0;
      end
      if (terminal)          regs.irq_flag <= 1'b1;
      else if (regs.irq_clr) regs.irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_compare_gen.sv
// Bench for pwm_compare_gen: a model main counter honours cnt_clr, and the
// expected waveform is derived from a per-cycle schedule of (position, period, duty).
module tb_pwm_compare_gen;
  localparam int CW = 16;

  logic          slow_clk = 1'b0;
  logic          rst, soft_rst, enable, one_shot;
  logic [CW-1:0] cnt;
  logic          pwm_out, cnt_clr, busy;

  pwm_compare_gen_if #(.CW(CW)) regs ();

  pwm_compare_gen #(.CW(CW)) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .enable   (enable),
    .one_shot (one_shot),
    .cnt      (cnt),
    .regs     (regs.slave),
    .pwm_out  (pwm_out),
    .cnt_clr  (cnt_clr),
    .busy     (busy)
  );

  always #5 slow_clk = ~slow_clk;

  int   checks = 0;
  int   errors = 0;
  logic s_clr, s_pwm, s_busy, s_flag, s_irq;

  // expected schedule: counter position, period and duty in force for each RUN cycle
  int sp[$];
  int sper[$];
  int sduty[$];

  task automatic tick;
    @(negedge slow_clk);
    s_clr  = cnt_clr;
    s_pwm  = pwm_out;
    s_busy = busy;
    s_flag = regs.irq_flag;
    s_irq  = regs.irq;
    @(posedge slow_clk);
    #1;
    cnt = s_clr ? 16'd0 : (s_busy ? cnt + 16'd1 : cnt);
  endtask

  task automatic do_reset;
    rst = 1'b1; soft_rst = 1'b0; enable = 1'b0; one_shot = 1'b0; cnt = '0;
    regs.load = 1'b0; regs.period_wr = '0; regs.duty_wr = '0;
    regs.irq_en = 1'b0; regs.irq_clr = 1'b0;
    sp.delete(); sper.delete(); sduty.delete();
    @(posedge slow_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_vals(input int p, input int d);
    regs.period_wr = p[CW-1:0];
    regs.duty_wr   = d[CW-1:0];
    regs.load      = 1'b1;
    tick;
    regs.load      = 1'b0;
  endtask

  task automatic start(output bit ok);
    int n;
    n = 0;
    enable = 1'b1;
    while (!busy && n < 10) begin
      tick;
      n++;
    end
    ok = busy;
  endtask

  task automatic add_seg(input int p, input int d, input int nper);
    for (int i = 0; i < nper; i++)
      for (int j = 0; j < p; j++) begin
        sp.push_back(j); sper.push_back(p); sduty.push_back(d);
      end
  endtask

  task automatic test_reset;
    rst = 1'b1; soft_rst = 1'b0; enable = 1'b0; one_shot = 1'b0; cnt = '0;
    regs.load = 1'b0; regs.period_wr = '0; regs.duty_wr = '0;
    regs.irq_en = 1'b1; regs.irq_clr = 1'b0;
    @(posedge slow_clk);
    #1;
    checks += 4;
    if (pwm_out !== 1'b0)       begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    if (cnt_clr !== 1'b0)       begin errors++; $display("FAIL reset_clr got %b want 0", cnt_clr); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (regs.irq !== 1'b0)      begin errors++; $display("FAIL reset_irq got %b want 0", regs.irq); end
    rst = 1'b0;
    tick;
    checks += 2;
    if (s_flag !== 1'b0)        begin errors++; $display("FAIL reset_flag got %b want 0", s_flag); end
    if (s_busy !== 1'b0)        begin errors++; $display("FAIL reset_busy2 got %b want 0", s_busy); end
  endtask

  task automatic test_continuous;
    bit ok, seen, e_clr, e_pwm;
    do_reset;
    load_vals(10, 3);
    start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_start busy=%b want 1", busy); end
    add_seg(10, 3, 3);
    seen = 0;
    for (int k = 0; k < sp.size(); k++) begin
      tick;
      e_clr = (sp[k] == sper[k] - 1);
      e_pwm = (k > 0) && (sp[k-1] < sduty[k-1]);
      checks += 3;
      if (s_clr !== e_clr)  begin errors++; $display("FAIL cont_clr k=%0d got %b want %b", k, s_clr, e_clr); end
      if (s_pwm !== e_pwm)  begin errors++; $display("FAIL cont_pwm k=%0d got %b want %b", k, s_pwm, e_pwm); end
      if (s_flag !== seen)  begin errors++; $display("FAIL cont_flag k=%0d got %b want %b", k, s_flag, seen); end
      if (e_clr) seen = 1;
    end
  endtask

  task automatic test_shadow;
    bit ok, e_clr, e_pwm;
    int ld_k[$], ld_p[$], ld_d[$];
    for (int sc = 0; sc < 2; sc++) begin
      do_reset;
      ld_k.delete(); ld_p.delete(); ld_d.delete();
      if (sc == 0) begin
        ld_k.push_back(5); ld_p.push_back(4); ld_d.push_back(2);
        add_seg(10, 3, 1); add_seg(4, 2, 4);
      end else begin
        // second load lands on the terminal cycle: the earlier one transfers first
        ld_k.push_back(2); ld_p.push_back(6); ld_d.push_back(4);
        ld_k.push_back(9); ld_p.push_back(4); ld_d.push_back(1);
        add_seg(10, 3, 1); add_seg(6, 4, 1); add_seg(4, 1, 3);
      end
      load_vals(10, 3);
      start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL shadow_start sc=%0d busy=%b want 1", sc, busy); end
      for (int k = 0; k < sp.size(); k++) begin
        for (int i = 0; i < ld_k.size(); i++)
          if (ld_k[i] == k) begin
            regs.period_wr = ld_p[i][CW-1:0];
            regs.duty_wr   = ld_d[i][CW-1:0];
            regs.load      = 1'b1;
          end
        tick;
        regs.load = 1'b0;
        e_clr = (sp[k] == sper[k] - 1);
        e_pwm = (k > 0) && (sp[k-1] < sduty[k-1]);
        checks += 2;
        if (s_clr !== e_clr) begin errors++; $display("FAIL shadow_clr sc=%0d k=%0d got %b want %b", sc, k, s_clr, e_clr); end
        if (s_pwm !== e_pwm) begin errors++; $display("FAIL shadow_pwm sc=%0d k=%0d got %b want %b", sc, k, s_pwm, e_pwm); end
      end
    end
  endtask

  task automatic test_one_shot;
    bit ok, e_clr, e_pwm, e_busy;
    do_reset;
    one_shot = 1'b1;
    load_vals(5, 5);
    start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL os_start busy=%b want 1", busy); end
    for (int k = 0; k < 12; k++) begin
      tick;
      e_clr  = (k == 4);
      e_pwm  = (k >= 1) && (k <= 5);
      e_busy = (k <= 4);
      checks += 3;
      if (s_clr !== e_clr)   begin errors++; $display("FAIL os_clr k=%0d got %b want %b", k, s_clr, e_clr); end
      if (s_pwm !== e_pwm)   begin errors++; $display("FAIL os_pwm k=%0d got %b want %b", k, s_pwm, e_pwm); end
      if (s_busy !== e_busy) begin errors++; $display("FAIL os_busy k=%0d got %b want %b", k, s_busy, e_busy); end
    end
    enable = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL os_idle_busy got %b want 0", busy); end
    // returning to IDLE (not stuck in DONE) means a fresh enable restarts
    enable = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL os_restart got %b want 1", busy); end
    one_shot = 1'b0;
  endtask

  task automatic test_boundary;
    bit ok, e_clr, e_pwm;
    int bp[3] = '{1, 7, 8};
    int bd[3] = '{1, 0, 65535};
    do_reset;
    load_vals(0, 3);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks += 3;
      if (s_busy !== 1'b0) begin errors++; $display("FAIL p0_busy k=%0d got %b want 0", k, s_busy); end
      if (s_clr !== 1'b0)  begin errors++; $display("FAIL p0_clr k=%0d got %b want 0", k, s_clr); end
      if (s_flag !== 1'b0) begin errors++; $display("FAIL p0_flag k=%0d got %b want 0", k, s_flag); end
    end
    for (int b = 0; b < 3; b++) begin
      do_reset;
      add_seg(bp[b], bd[b], 24 / bp[b]);
      load_vals(bp[b], bd[b]);
      start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bnd_start b=%0d busy=%b want 1", b, busy); end
      for (int k = 0; k < sp.size(); k++) begin
        tick;
        e_clr = (sp[k] == sper[k] - 1);
        e_pwm = (k > 0) && (sp[k-1] < sduty[k-1]);
        checks += 3;
        if (s_clr !== e_clr) begin errors++; $display("FAIL bnd_clr b=%0d k=%0d got %b want %b", b, k, s_clr, e_clr); end
        if (s_pwm !== e_pwm) begin errors++; $display("FAIL bnd_pwm b=%0d k=%0d got %b want %b", b, k, s_pwm, e_pwm); end
        if (s_flag !== (k >= bp[b])) begin errors++; $display("FAIL bnd_flag b=%0d k=%0d got %b want %b", b, k, s_flag, (k >= bp[b])); end
      end
    end
  endtask

  task automatic test_irq;
    bit ok;
    do_reset;
    load_vals(3, 1);
    start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL irq_start busy=%b want 1", busy); end
    repeat (4) tick;
    checks += 2;
    if (s_flag !== 1'b1) begin errors++; $display("FAIL irq_flag_set got %b want 1", s_flag); end
    if (s_irq !== 1'b0)  begin errors++; $display("FAIL irq_masked got %b want 0", s_irq); end
    regs.irq_en = 1'b1;
    #1;
    checks++;
    if (regs.irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked got %b want 1", regs.irq); end
    tick;
    regs.irq_clr = 1'b1;
    tick;
    regs.irq_clr = 1'b0;
    checks += 2;
    if (s_clr !== 1'b1)         begin errors++; $display("FAIL irq_term_cycle got %b want 1", s_clr); end
    if (regs.irq_flag !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", regs.irq_flag); end
    regs.irq_clr = 1'b1;
    tick;
    regs.irq_clr = 1'b0;
    checks += 2;
    if (regs.irq_flag !== 1'b0) begin errors++; $display("FAIL irq_clr got %b want 0", regs.irq_flag); end
    if (regs.irq !== 1'b0)      begin errors++; $display("FAIL irq_after_clr got %b want 0", regs.irq); end
    regs.irq_clr = 1'b1;
    tick;
    regs.irq_clr = 1'b0;
    checks++;
    if (regs.irq_flag !== 1'b0) begin errors++; $display("FAIL irq_clr_idle got %b want 0", regs.irq_flag); end
    tick;
    checks++;
    if (regs.irq_flag !== 1'b1) begin errors++; $display("FAIL irq_reset_again got %b want 1", regs.irq_flag); end
  endtask

  task automatic test_resets;
    bit ok;
    for (int sc = 0; sc < 2; sc++) begin
      do_reset;
      load_vals(10, 8);
      start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_start sc=%0d busy=%b want 1", sc, busy); end
      for (int k = 0; k < 16; k++) begin
        if (k == 14) begin
          regs.period_wr = 16'd5; regs.duty_wr = 16'd2; regs.load = 1'b1;
        end
        tick;
        regs.load = 1'b0;
      end
      checks++;
      if (cnt !== 16'd6) begin errors++; $display("FAIL rst_pos sc=%0d got %0d want 6", sc, cnt); end
      if (sc == 0) begin
        rst = 1'b1;
        #1;
      end else begin
        soft_rst = 1'b1;
        #1;
        checks += 2;
        if (busy !== 1'b1)    begin errors++; $display("FAIL srst_early_busy got %b want 1", busy); end
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL srst_early_pwm got %b want 1", pwm_out); end
        tick;
        soft_rst = 1'b0;
      end
      checks += 4;
      if (pwm_out !== 1'b0)       begin errors++; $display("FAIL rst_pwm sc=%0d got %b want 0", sc, pwm_out); end
      if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy sc=%0d got %b want 0", sc, busy); end
      if (regs.irq_flag !== 1'b0) begin errors++; $display("FAIL rst_flag sc=%0d got %b want 0", sc, regs.irq_flag); end
      if (cnt_clr !== 1'b0)       begin errors++; $display("FAIL rst_clr sc=%0d got %b want 0", sc, cnt_clr); end
      cnt = '0;
      if (sc == 0) begin
        tick;
        rst = 1'b0;
      end
      // active and pending both cleared: enable alone must not start a period
      for (int k = 0; k < 5; k++) begin
        tick;
        checks += 2;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy sc=%0d k=%0d got %b want 0", sc, k, s_busy); end
        if (s_clr !== 1'b0)  begin errors++; $display("FAIL rst_idle_clr sc=%0d k=%0d got %b want 0", sc, k, s_clr); end
      end
    end
  endtask

  task automatic test_overrun;
    bit ok, e_clr, e_pwm;
    do_reset;
    load_vals(8, 3);
    tick;
    cnt = 16'd20;
    start(ok);
    checks += 2;
    if (!ok)              begin errors++; $display("FAIL ovr_start busy=%b want 1", busy); end
    if (cnt_clr !== 1'b1) begin errors++; $display("FAIL ovr_first_clr got %b want 1", cnt_clr); end
    tick;
    for (int k = 1; k <= 9; k++) begin
      tick;
      e_clr = ((k - 1) % 8 == 7);
      e_pwm = (k >= 2) && (((k - 2) % 8) < 3);
      checks += 2;
      if (s_clr !== e_clr) begin errors++; $display("FAIL ovr_clr k=%0d got %b want %b", k, s_clr, e_clr); end
      if (s_pwm !== e_pwm) begin errors++; $display("FAIL ovr_pwm k=%0d got %b want %b", k, s_pwm, e_pwm); end
    end
  endtask

  task automatic test_random;
    bit ok, e_clr, e_pwm;
    int p1, d1, p2, d2, j0;
    for (int it = 0; it < 8; it++) begin
      do_reset;
      p1 = int'($urandom_range(12, 2));
      d1 = int'($urandom_range(14, 0));
      p2 = int'($urandom_range(12, 1));
      d2 = int'($urandom_range(14, 0));
      j0 = int'($urandom_range(p1 - 2, 0));
      add_seg(p1, d1, 1);
      add_seg(p2, d2, 3);
      load_vals(p1, d1);
      start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_start it=%0d busy=%b want 1", it, busy); end
      for (int k = 0; k < sp.size(); k++) begin
        if (k == j0) begin
          regs.period_wr = p2[CW-1:0]; regs.duty_wr = d2[CW-1:0]; regs.load = 1'b1;
        end
        tick;
        regs.load = 1'b0;
        e_clr = (sp[k] == sper[k] - 1);
        e_pwm = (k > 0) && (sp[k-1] < sduty[k-1]);
        checks += 2;
        if (s_clr !== e_clr) begin errors++; $display("FAIL rnd_clr it=%0d p=%0d/%0d d=%0d/%0d k=%0d got %b want %b", it, p1, p2, d1, d2, k, s_clr, e_clr); end
        if (s_pwm !== e_pwm) begin errors++; $display("FAIL rnd_pwm it=%0d p=%0d/%0d d=%0d/%0d k=%0d got %b want %b", it, p1, p2, d1, d2, k, s_pwm, e_pwm); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_shadow;
    test_one_shot;
    test_boundary;
    test_irq;
    test_resets;
    test_overrun;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
